// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and index-match helper for the multi-port register file
// Exports X0_IDX, MAX_REGS (upper bound on REG_COUNT) and onehot_idx_match.
package regfile_pkg;
  localparam int X0_IDX = 0;
  localparam int MAX_REGS = 256;
  // vec is a one-hot (or zero) decoded write target; returns whether it hits idx
  function automatic logic onehot_idx_match(input logic [7:0] idx, input logic [MAX_REGS-1:0] vec);
    return vec[idx];
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush > alloc > clear priority
// Ports: clk, rst (async, active-high), alloc_en/alloc_idx (mark busy),
// flush (clear all), clr_vec (registers written this cycle), busy_vec (state, bit 0 always 0).
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int REG_COUNT = 32,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_idx,
  input  logic                 flush,
  input  logic [REG_COUNT-1:0] clr_vec,
  output logic [REG_COUNT-1:0] busy_vec
);
  typedef logic [REG_COUNT-1:0] busy_t;
  busy_t busy, alloc_vec, x0_mask;
  assign alloc_vec = alloc_en ? busy_t'(1) << alloc_idx : '0;
  assign x0_mask = ~(busy_t'(1) << X0_IDX);
  // alloc is OR-ed after the clear so a new producer supersedes a same-cycle writeback
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else if (flush) busy <= '0;
    else busy <= ((busy & ~clr_vec) | alloc_vec) & x0_mask;
  assign busy_vec = busy;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with write-to-read bypass and busy scoreboard
// Ports: clk, rst (async, active-high); rd_idx/rd_data/rd_ready per read port;
// wr_en/wr_idx/wr_data per write port; alloc_en/alloc_idx, flush; busy_vec.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int XLEN = 64,
  parameter int REG_COUNT = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_idx,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_ready,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_idx,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_idx,
  input  logic                   flush,
  output logic [REG_COUNT-1:0]   busy_vec
);
  logic [XLEN-1:0] regs [REG_COUNT];
  logic [MAX_REGS-1:0] wdec [NUM_WR];
  logic [REG_COUNT-1:0] clr_vec;
  always_comb begin
    clr_vec = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wdec[w] = wr_en[w] ? MAX_REGS'(1) << wr_idx[w*AW +: AW] : '0;
      clr_vec = clr_vec | wdec[w][REG_COUNT-1:0];
    end
  end
  // ascending port order: the highest-numbered port's assignment lands last and wins
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
    else for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_idx[w*AW +: AW] != AW'(X0_IDX)) regs[wr_idx[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
  // reads are forced to 0/ready during reset so a live write cannot leak through the bypass
  always_comb begin : rd_mux
    logic [AW-1:0] idx;
    logic [XLEN-1:0] d;
    logic rdy;
    rd_data = '0;
    rd_ready = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx = rd_idx[p*AW +: AW];
      d = regs[idx];
      rdy = !busy_vec[idx];
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WR; w++)
          if (onehot_idx_match(8'(idx), wdec[w])) begin
            d = wr_data[w*XLEN +: XLEN];
            rdy = 1'b1;
          end
      rd_data[p*XLEN +: XLEN] = (rst || idx == AW'(X0_IDX)) ? '0 : d;
      rd_ready[p] = rst || idx == AW'(X0_IDX) || rdy;
    end
  end
  regfile_scoreboard #(.REG_COUNT(REG_COUNT)) u_sb (
    .clk(clk),
    .rst(rst),
    .alloc_en(alloc_en),
    .alloc_idx(alloc_idx),
    .flush(flush),
    .clr_vec(clr_vec),
    .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and randomized checks of two regfile_mp_sb configurations against array models
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [9:0] a_rd_idx;
  logic [127:0] a_rd_data;
  logic [1:0] a_rd_ready;
  logic [1:0] a_wr_en;
  logic [9:0] a_wr_idx;
  logic [127:0] a_wr_data;
  logic a_alloc_en;
  logic [4:0] a_alloc_idx;
  logic a_flush;
  logic [31:0] a_busy;
  logic [15:0] b_rd_idx;
  logic [255:0] b_rd_data;
  logic [3:0] b_rd_ready;
  logic [1:0] b_wr_en;
  logic [7:0] b_wr_idx;
  logic [127:0] b_wr_data;
  logic b_alloc_en;
  logic [3:0] b_alloc_idx;
  logic b_flush;
  logic [15:0] b_busy;
  regfile_mp_sb #(.XLEN(64), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_idx(a_rd_idx), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
    .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_data(a_wr_data), .alloc_en(a_alloc_en),
    .alloc_idx(a_alloc_idx), .flush(a_flush), .busy_vec(a_busy));
  regfile_mp_sb #(.XLEN(64), .REG_COUNT(16), .NUM_RD(4), .NUM_WR(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
    .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data), .alloc_en(b_alloc_en),
    .alloc_idx(b_alloc_idx), .flush(b_flush), .busy_vec(b_busy));
  logic [63:0] ma [32];
  bit ba [32];
  logic [63:0] mb [16];
  bit bb [16];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic clear_models();
    for (int r = 0; r < 32; r++) begin ma[r] = '0; ba[r] = 0; end
    for (int r = 0; r < 16; r++) begin mb[r] = '0; bb[r] = 0; end
  endtask
  task automatic a_idle();
    a_rd_idx = '0; a_wr_en = '0; a_wr_idx = '0; a_wr_data = '0;
    a_alloc_en = 0; a_alloc_idx = '0; a_flush = 0;
  endtask
  task automatic b_idle();
    b_rd_idx = '0; b_wr_en = '0; b_wr_idx = '0; b_wr_data = '0;
    b_alloc_en = 0; b_alloc_idx = '0; b_flush = 0;
  endtask
  // model of one clock edge: writes (last port wins, x0 ignored), busy flush > alloc > clear
  task automatic tick();
    bit nb [32];
    @(posedge clk);
    if (rst) clear_models();
    else begin
      for (int r = 0; r < 32; r++) begin
        nb[r] = ba[r];
        for (int w = 0; w < 2; w++) if (a_wr_en[w] && int'(a_wr_idx[w*5 +: 5]) == r) nb[r] = 0;
        if (a_alloc_en && int'(a_alloc_idx) == r && r != 0) nb[r] = 1;
        if (a_flush) nb[r] = 0;
      end
      for (int r = 0; r < 32; r++) ba[r] = nb[r];
      for (int w = 0; w < 2; w++) if (a_wr_en[w] && a_wr_idx[w*5 +: 5] != 0) ma[a_wr_idx[w*5 +: 5]] = a_wr_data[w*64 +: 64];
      for (int r = 0; r < 16; r++) begin
        nb[r] = bb[r];
        for (int w = 0; w < 2; w++) if (b_wr_en[w] && int'(b_wr_idx[w*4 +: 4]) == r) nb[r] = 0;
        if (b_alloc_en && int'(b_alloc_idx) == r && r != 0) nb[r] = 1;
        if (b_flush) nb[r] = 0;
      end
      for (int r = 0; r < 16; r++) bb[r] = nb[r];
      for (int w = 0; w < 2; w++) if (b_wr_en[w] && b_wr_idx[w*4 +: 4] != 0) mb[b_wr_idx[w*4 +: 4]] = b_wr_data[w*64 +: 64];
    end
    #1;
  endtask
  function automatic logic [63:0] exp_a_data(input int idx);
    logic [63:0] d = ma[idx];
    for (int w = 0; w < 2; w++) if (a_wr_en[w] && int'(a_wr_idx[w*5 +: 5]) == idx) d = a_wr_data[w*64 +: 64];
    return idx == 0 ? 64'd0 : d;
  endfunction
  function automatic logic exp_a_rdy(input int idx);
    logic r = !ba[idx];
    for (int w = 0; w < 2; w++) if (a_wr_en[w] && int'(a_wr_idx[w*5 +: 5]) == idx) r = 1;
    return idx == 0 || r;
  endfunction
  task automatic check_a(input string tag);
    logic [31:0] v;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_a_rd%0d", tag, p), a_rd_data[p*64 +: 64], exp_a_data(int'(a_rd_idx[p*5 +: 5])));
      chk($sformatf("%s_a_rdy%0d", tag, p), 64'(a_rd_ready[p]), 64'(exp_a_rdy(int'(a_rd_idx[p*5 +: 5]))));
    end
    for (int r = 0; r < 32; r++) v[r] = ba[r];
    chk({tag, "_a_busy"}, 64'(a_busy), 64'(v));
  endtask
  task automatic check_b(input string tag);
    logic [15:0] v;
    int idx;
    for (int p = 0; p < 4; p++) begin
      idx = int'(b_rd_idx[p*4 +: 4]);
      chk($sformatf("%s_b_rd%0d", tag, p), b_rd_data[p*64 +: 64], idx == 0 ? 64'd0 : mb[idx]);
      chk($sformatf("%s_b_rdy%0d", tag, p), 64'(b_rd_ready[p]), 64'(idx == 0 || !bb[idx]));
    end
    for (int r = 0; r < 16; r++) v[r] = bb[r];
    chk({tag, "_b_busy"}, 64'(b_busy), 64'(v));
  endtask
  initial begin
    rst = 1;
    a_idle();
    b_idle();
    clear_models();
    tick();
    tick();
    rst = 0;
    for (int n = 1; n < 32; n++) begin
      a_wr_en = 2'b01;
      a_wr_idx = {5'd0, 5'(n)};
      a_wr_data = {64'd0, 64'hA5A5_0000_0000_0000 | 64'(n)};
      tick();
    end
    a_idle();
    a_alloc_en = 1;
    a_alloc_idx = 5'd4;
    tick();
    a_idle();
    a_rd_idx = {5'd31, 5'd5};
    #2;
    chk("fill_x5", a_rd_data[63:0], 64'hA5A5_0000_0000_0005);
    chk("fill_x31", a_rd_data[127:64], 64'hA5A5_0000_0000_001F);
    check_a("fill");
    rst = 1;
    clear_models();
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd5};
    a_wr_data = {64'd0, 64'hDEAD_BEEF};
    #1;
    chk("rst_x5", a_rd_data[63:0], 64'd0);
    chk("rst_x31", a_rd_data[127:64], 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_ready", 64'(a_rd_ready), 64'd3);
    tick();
    rst = 0;
    a_idle();
    a_rd_idx = {5'd31, 5'd5};
    #2;
    check_a("post_rst");
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd7};
    a_wr_data = {64'd0, 64'h1234};
    a_rd_idx = {5'd1, 5'd7};
    #2;
    chk("byp_x7", a_rd_data[63:0], 64'h1234);
    check_a("byp");
    tick();
    a_idle();
    a_rd_idx = {5'd0, 5'd7};
    #2;
    chk("x7_after", a_rd_data[63:0], 64'h1234);
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd0};
    a_wr_data = {64'd0, 64'hFFFF};
    a_rd_idx = {5'd0, 5'd0};
    #2;
    chk("x0_byp", a_rd_data[63:0], 64'd0);
    tick();
    a_idle();
    #2;
    chk("x0_after", a_rd_data[63:0], 64'd0);
    a_alloc_en = 1;
    a_alloc_idx = 5'd10;
    tick();
    a_idle();
    a_rd_idx = {5'd0, 5'd10};
    #2;
    chk("alloc_busy", 64'(a_busy[10]), 64'd1);
    chk("alloc_ready", 64'(a_rd_ready[0]), 64'd0);
    tick();
    tick();
    a_wr_en = 2'b01;
    a_wr_idx = {5'd0, 5'd10};
    a_wr_data = {64'd0, 64'h55};
    #2;
    chk("wb_ready", 64'(a_rd_ready[0]), 64'd1);
    chk("wb_data", a_rd_data[63:0], 64'h55);
    chk("wb_busy_same", 64'(a_busy[10]), 64'd1);
    tick();
    a_idle();
    a_rd_idx = {5'd0, 5'd10};
    #2;
    chk("wb_busy_clr", 64'(a_busy[10]), 64'd0);
    a_alloc_en = 1;
    a_alloc_idx = 5'd10;
    a_wr_en = 2'b10;
    a_wr_idx = {5'd10, 5'd0};
    a_wr_data = {64'h66, 64'd0};
    tick();
    a_idle();
    #2;
    chk("waw_busy", 64'(a_busy[10]), 64'd1);
    check_a("waw");
    a_wr_en = 2'b11;
    a_wr_idx = {5'd3, 5'd3};
    a_wr_data = {64'h22, 64'h11};
    a_rd_idx = {5'd3, 5'd3};
    #2;
    chk("dual_byp", a_rd_data[63:0], 64'h22);
    tick();
    a_idle();
    a_rd_idx = {5'd0, 5'd3};
    #2;
    chk("dual_x3", a_rd_data[63:0], 64'h22);
    a_alloc_en = 1;
    a_alloc_idx = 5'd12;
    tick();
    a_flush = 1;
    a_alloc_idx = 5'd9;
    #2;
    chk("pre_flush_busy", 64'(a_busy), 64'h1400);
    tick();
    a_idle();
    #2;
    chk("flush_busy", 64'(a_busy), 64'd0);
    for (int c = 0; c < 10000; c++) begin
      a_wr_en = 2'($urandom);
      a_wr_idx = 10'($urandom);
      a_wr_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      a_rd_idx = 10'($urandom);
      if ($urandom_range(1, 0) == 1) a_rd_idx[4:0] = a_wr_idx[4:0];
      if ($urandom_range(3, 0) == 0) a_rd_idx[9:5] = a_wr_idx[9:5];
      a_alloc_en = $urandom_range(2, 0) == 0;
      a_alloc_idx = 5'($urandom);
      a_flush = $urandom_range(15, 0) == 0;
      b_wr_en = 2'($urandom);
      b_wr_idx = 8'($urandom);
      b_wr_data = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      b_rd_idx = 16'($urandom);
      if ($urandom_range(1, 0) == 1) b_rd_idx[3:0] = b_wr_idx[3:0];
      if ($urandom_range(1, 0) == 1) b_rd_idx[11:8] = b_wr_idx[7:4];
      b_alloc_en = $urandom_range(2, 0) == 0;
      b_alloc_idx = 4'($urandom);
      b_flush = $urandom_range(15, 0) == 0;
      #2;
      check_a($sformatf("rnd%0d", c));
      check_b($sformatf("rnd%0d", c));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
